// File: rtl/stream_parity_gen_chk_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_parity_gen_chk_if
// Description : Stream bundle for stream_parity_gen_chk. It carries the
//               upstream word channel (in_*) and the downstream beat channel
//               (out_*) together with their valid/ready handshakes.
//   slave  modport : the parity block's view (consumes in_*, produces out_*)
//   master modport : the environment's view (produces in_*, consumes out_*)
// Signals:
//   in_valid/in_ready   : upstream handshake
//   in_data             : DATA_WIDTH-bit word
//   in_parity           : received word parity (check mode)
//   in_fpar             : received frame parity, meaningful on the last beat
//   in_last             : early end of frame
//   out_valid/out_ready : downstream handshake
//   out_data            : registered copy of the accepted word
//   out_parity          : computed word parity
//   out_last            : beat closes the frame
//   out_fpar            : computed frame parity (with out_last)
//   out_err/out_ferr    : word / frame parity mismatch (check mode)
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_parity_gen_chk_if #(
  parameter int DATA_WIDTH = 8
);
  // upstream channel
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_parity;
  logic                  in_fpar;
  logic                  in_last;

  // downstream channel
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_parity;
  logic                  out_last;
  logic                  out_fpar;
  logic                  out_err;
  logic                  out_ferr;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_parity,
    input  in_fpar,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_parity,
    output out_last,
    output out_fpar,
    output out_err,
    output out_ferr
  );

  modport master (
    output in_valid,
    output in_data,
    output in_parity,
    output in_fpar,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_parity,
    input  out_last,
    input  out_fpar,
    input  out_err,
    input  out_ferr
  );
endinterface
`default_nettype wire

// File: rtl/stream_parity_gen_chk.sv
`default_nettype none
// ============================================================================
// Module      : stream_parity_gen_chk
// Description : Streaming word/frame parity generator and checker. Words pass
//               through a single registered valid/ready stage. Each word gets
//               an even/odd parity bit (or has its received parity checked);
//               each frame of up to FRAME_LEN words gets a frame parity bit
//               (or has its received frame parity checked). Errors feed a
//               sticky flag and a saturating counter.
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   mode_odd   : 0 = even, 1 = odd parity (sampled on a frame's first beat)
//   check_en   : 0 = generate, 1 = check (sampled on a frame's first beat)
//   clr_err    : synchronous clear of err_flag / err_count
//   err_flag   : sticky error indicator
//   err_count  : saturating count of errored beats
//   bus        : stream bundle (slave view), see stream_parity_gen_chk_if
// Parameters:
//   DATA_WIDTH  : word width in bits (>=1)
//   FRAME_LEN   : maximum words per frame (>=2)
//   COUNT_WIDTH : error counter width
// Revision    : 1.0 - initial release
// ============================================================================
module stream_parity_gen_chk #(
  parameter int DATA_WIDTH  = 8,
  parameter int FRAME_LEN   = 4,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode_odd,
  input  logic                   check_en,
  input  logic                   clr_err,
  output logic                   err_flag,
  output logic [COUNT_WIDTH-1:0] err_count,
  stream_parity_gen_chk_if.slave bus
);

  // Word counter only needs to reach FRAME_LEN-1 before wrapping to 0.
  localparam int                     c_cnt_width = $clog2(FRAME_LEN);
  localparam logic [c_cnt_width-1:0] c_last_idx  = c_cnt_width'(FRAME_LEN - 1);
  localparam logic [COUNT_WIDTH-1:0] c_count_max = {COUNT_WIDTH{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  state_t                   r_state;
  logic [c_cnt_width-1:0]   r_count;
  logic                     r_acc;
  logic                     r_mode_odd;
  logic                     r_check_en;

  logic                     r_out_valid;
  logic [DATA_WIDTH-1:0]    r_out_data;
  logic                     r_out_parity;
  logic                     r_out_last;
  logic                     r_out_fpar;
  logic                     r_out_err;
  logic                     r_out_ferr;

  logic                     r_err_flag;
  logic [COUNT_WIDTH-1:0]   r_err_count;

  // --------------------------------------------------------------------------
  // Combinational datapath
  // --------------------------------------------------------------------------
  state_t                   w_state_next;
  logic [c_cnt_width-1:0]   w_count_next;
  logic                     w_acc_next;

  logic                     w_in_ready;
  logic                     w_accept;
  logic                     w_in_frame;
  logic                     w_mode;
  logic                     w_chk;
  logic                     w_word_xor;
  logic                     w_acc_base;
  logic                     w_word_par;
  logic                     w_frame_par;
  logic                     w_last;
  logic                     w_word_err;
  logic                     w_frame_err;
  logic                     w_beat_err;

  logic                     w_err_flag_next;
  logic [COUNT_WIDTH-1:0]   w_err_count_next;
  logic [COUNT_WIDTH-1:0]   w_cnt_base;

  // The stage can take a word whenever it is empty or its beat leaves now.
  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

  // On a frame's first beat the live mode inputs apply; afterwards the
  // latched copies do, so mid-frame mode changes have no effect.
  assign w_in_frame = (r_state == ST_FRAME);
  assign w_mode     = w_in_frame ? r_mode_odd : mode_odd;
  assign w_chk      = w_in_frame ? r_check_en : check_en;

  assign w_word_xor  = ^bus.in_data;
  assign w_acc_base  = w_in_frame ? r_acc : 1'b0;
  assign w_word_par  = w_word_xor ^ w_mode;
  assign w_frame_par = w_acc_base ^ w_word_xor ^ w_mode;

  // r_count is 0 in IDLE and FRAME_LEN>=2, so the count term can only close
  // a frame that is already in progress.
  assign w_last = bus.in_last || (r_count == c_last_idx);

  assign w_word_err  = w_chk && (w_word_par != bus.in_parity);
  assign w_frame_err = w_chk && w_last && (w_frame_par != bus.in_fpar);
  assign w_beat_err  = w_accept && (w_word_err || w_frame_err);

  // --------------------------------------------------------------------------
  // Frame FSM: next-state, word counter and frame accumulator
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_acc_next   = r_acc;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_last) begin
            // Single-beat frame: closes immediately, nothing carried over.
            w_state_next = ST_IDLE;
            w_count_next = '0;
            w_acc_next   = 1'b0;
          end else begin
            w_state_next = ST_FRAME;
            w_count_next = c_cnt_width'(1);
            w_acc_next   = w_word_xor;
          end
        end
      end
      ST_FRAME: begin
        if (w_accept) begin
          if (w_last) begin
            w_state_next = ST_IDLE;
            w_count_next = '0;
            w_acc_next   = 1'b0;
          end else begin
            w_count_next = r_count + c_cnt_width'(1);
            w_acc_next   = r_acc ^ w_word_xor;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_count_next = '0;
        w_acc_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_acc      <= 1'b0;
      r_mode_odd <= 1'b0;
      r_check_en <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_acc   <= w_acc_next;
      if (w_accept && !w_in_frame) begin
        r_mode_odd <= mode_odd;
        r_check_en <= check_en;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output stage: loads on accept, otherwise holds; valid drops once the
  // beat has been taken with nothing new behind it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_parity <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_fpar   <= 1'b0;
      r_out_err    <= 1'b0;
      r_out_ferr   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid  <= 1'b1;
      r_out_data   <= bus.in_data;
      r_out_parity <= w_word_par;
      r_out_last   <= w_last;
      r_out_fpar   <= w_last ? w_frame_par : 1'b0;
      r_out_err    <= w_word_err;
      r_out_ferr   <= w_frame_err;
    end else if (bus.out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Error bookkeeping: a clear in the same cycle as a new error is applied
  // first, so the new error still counts. One increment per errored beat.
  // --------------------------------------------------------------------------
  always_comb begin
    w_cnt_base       = clr_err ? '0 : r_err_count;
    w_err_flag_next  = (clr_err ? 1'b0 : r_err_flag) | w_beat_err;
    w_err_count_next = w_cnt_base;
    if (w_beat_err && (w_cnt_base != c_count_max)) begin
      w_err_count_next = w_cnt_base + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_flag  <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_flag  <= w_err_flag_next;
      r_err_count <= w_err_count_next;
    end
  end

  // --------------------------------------------------------------------------
  // Port drive
  // --------------------------------------------------------------------------
  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_parity = r_out_parity;
  assign bus.out_last   = r_out_last;
  assign bus.out_fpar   = r_out_fpar;
  assign bus.out_err    = r_out_err;
  assign bus.out_ferr   = r_out_ferr;
  assign err_flag       = r_err_flag;
  assign err_count      = r_err_count;

endmodule
`default_nettype wire
